// File: rtl/stats_readout_bridge.sv
// Streams words from a stats BRAM read port into a small response FIFO.
// Build option: STATS_READ_BURST_EN enables multi-beat bursts; without it, every request returns one beat.
module stats_readout_bridge #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] bram_addr,
  output logic              bram_en,
  input  logic [DATA_W-1:0] bram_rdata,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] L_DEPTH = (PTR_W+2)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        r_state;
  logic              r_bram_en;
  logic              r_en_last;
  logic [ADDR_W-1:0] r_bram_addr;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [PTR_W:0]    r_wr_ptr;
  logic [PTR_W:0]    r_rd_ptr;
  logic [DATA_W-1:0] r_mem_data [FIFO_DEPTH];
  logic              r_mem_last [FIFO_DEPTH];

  logic              w_accept;
  logic [PTR_W:0]    w_count;
  logic              w_empty;
  logic              w_pop;
  logic [1:0]        w_inflight;
  logic [PTR_W+1:0]  w_occ;
  logic              w_credit;
  logic              w_more;
  logic              w_first_last;
  logic              w_next_last;
  logic              w_issue;

  assign w_accept   = req_valid && req_ready;
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (w_count == '0);
  assign w_pop      = rsp_valid && rsp_ready;
  // Reads on the BRAM port or on the data bus still own a FIFO slot.
  assign w_inflight = {1'b0, r_bram_en} + {1'b0, r_rd_valid};
  assign w_occ      = {1'b0, w_count} + {{PTR_W{1'b0}}, w_inflight};
  assign w_credit   = (w_occ < L_DEPTH);
  assign w_issue    = (r_state == S_ISSUE) && w_more && w_credit;

`ifdef STATS_READ_BURST_EN
  logic [7:0] r_remaining;

  assign w_more       = (r_remaining != 8'd0);
  assign w_first_last = (req_len == 8'd0);
  assign w_next_last  = (r_remaining == 8'd1);

  // Counts reads still to issue after the one launched at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_remaining <= 8'd0;
    end else if (w_accept) begin
      r_remaining <= req_len;
    end else if (w_issue) begin
      r_remaining <= r_remaining - 8'd1;
    end
  end
`else
  logic w_unused_len;

  assign w_unused_len = ^req_len;
  assign w_more       = 1'b0;
  assign w_first_last = 1'b1;
  assign w_next_last  = 1'b1;
`endif

  // NOTE: reset is synchronous, so it sits inside the clocked branch and is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bram_en   <= 1'b0;
      r_en_last   <= 1'b0;
      r_bram_addr <= '0;
    end else begin
      r_bram_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_ISSUE;
            r_bram_en   <= 1'b1;
            r_bram_addr <= req_addr;
            r_en_last   <= w_first_last;
          end
        end
        S_ISSUE: begin
          if (w_issue) begin
            r_bram_en   <= 1'b1;
            r_bram_addr <= r_bram_addr + 1'b1;
            r_en_last   <= w_next_last;
          end
          if (!w_more) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if ((w_inflight == 2'd0) && w_empty) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // BRAM data is on the bus the cycle after bram_en; this stage marks when to capture it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
    end else begin
      r_rd_valid <= r_bram_en;
      r_rd_last  <= r_en_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (r_rd_valid) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (r_rd_valid) begin
      r_mem_data[r_wr_ptr[PTR_W-1:0]] <= bram_rdata;
      r_mem_last[r_wr_ptr[PTR_W-1:0]] <= r_rd_last;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign rsp_valid = !w_empty;
  assign rsp_data  = w_empty ? '0 : r_mem_data[r_rd_ptr[PTR_W-1:0]];
  assign rsp_last  = !w_empty && r_mem_last[r_rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_stats_readout_bridge.sv
// Self-checking bench for stats_readout_bridge: directed latency/corner sequences, a vector table,
// and randomized requests scored against a queue-based model of the expected beat stream.
module tb_stats_readout_bridge;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 64;
  localparam int FIFO_DEPTH = 4;
`ifdef STATS_READ_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;
  logic [ADDR_W-1:0] bram_addr;
  logic              bram_en;
  logic [DATA_W-1:0] bram_rdata;
  logic              busy;

  stats_readout_bridge #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_rdata(bram_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // BRAM contents are a fixed function of the address.
  bit scramble = 1'b0;
  function automatic logic [63:0] bram_word(input logic [15:0] a);
    if (a == 16'h0010) return 64'hDEADBEEFCAFEF00D;
    if (scramble) return {a ^ 16'h5A5A, ~a, a + 16'h1234, a};
    return {48'd0, a};
  endfunction

  initial bram_rdata = '0;
  always @(posedge clk) if (bram_en) bram_rdata <= bram_word(bram_addr);

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [15:0] iss_q[$];
  beat_t       mon_exp;
  int          beat_cnt  = 0;
  int          first_cyc = 0;
  int          last_cyc  = 0;
  int          cyc       = 0;
  logic [63:0] last_data = '0;
  bit          prev_hold = 1'b0;
  logic [63:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(rsp_valid), 64'd1);
        check("hold_data", rsp_data, prev_data);
        check("hold_last", 64'(rsp_last), 64'(prev_last));
      end
      if (bram_en) begin
        iss_q.push_back(bram_addr);
        check("en_outside_idle", 64'(req_ready), 64'd0);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(rsp_valid), 64'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat_data", rsp_data, mon_exp.data);
          check("beat_last", 64'(rsp_last), 64'(mon_exp.last));
        end
        if (beat_cnt == 0) first_cyc = cyc;
        last_cyc  = cyc;
        beat_cnt++;
        last_data = rsp_data;
      end
      prev_hold = rsp_valid && !rsp_ready;
      prev_data = rsp_data;
      prev_last = rsp_last;
    end
  end

  task automatic clear_stats();
    beat_cnt = 0;
    iss_q.delete();
  endtask

  task automatic model_push(input logic [15:0] a, input logic [7:0] l);
    int le;
    le = BURST ? int'(l) : 0;
    for (int i = 0; i <= le; i++) begin
      beat_t b;
      b.data = bram_word(a + 16'(i));
      b.last = (i == le);
      exp_q.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic do_req(input logic [15:0] a, input logic [7:0] l);
    int waited;
    waited = 0;
    while (!req_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_push(a, l);
  endtask

  task automatic wait_idle(input int budget, input bit rnd);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (rnd) rsp_ready = 1'($urandom_range(0, 1));
      if (!busy && exp_q.size() == 0) done = 1'b1;
    end
    check("complete", 64'(done), 64'd1);
    if (!done) exp_q.delete();
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    bit          rnd;
    int          exp_beats;
    logic [63:0] exp_last;
  } vec_t;

  vec_t        vecs[6];
  logic [15:0] wrap_exp[4];

  initial begin
    vecs[0] = '{16'h0020, 8'd5,  1'b0, BURST ? 6  : 1, BURST ? 64'h0025 : 64'h0020};
    vecs[1] = '{16'h0200, 8'd0,  1'b0, 1,              64'h0200};
    vecs[2] = '{16'h0300, 8'd2,  1'b1, BURST ? 3  : 1, BURST ? 64'h0302 : 64'h0300};
    vecs[3] = '{16'h7FFF, 8'd1,  1'b0, BURST ? 2  : 1, BURST ? 64'h8000 : 64'h7FFF};
    vecs[4] = '{16'hFFFF, 8'd4,  1'b1, BURST ? 5  : 1, BURST ? 64'h0003 : 64'hFFFF};
    vecs[5] = '{16'h0400, 8'd15, 1'b1, BURST ? 16 : 1, BURST ? 64'h040F : 64'h0400};
    wrap_exp = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_len   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_last", 64'(rsp_last), 64'd0);
    check("rst_bram_en", 64'(bram_en), 64'd0);
    check("rst_bram_addr", 64'(bram_addr), 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single read with latency probes around the accepting edge T.
    clear_stats();
    req_valid = 1'b1;
    req_addr  = 16'h0010;
    req_len   = 8'd0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    model_push(16'h0010, 8'd0);
    check("lat_en_T", 64'(bram_en), 64'd1);
    check("lat_addr_T", 64'(bram_addr), 64'h0010);
    check("lat_busy_T", 64'(busy), 64'd1);
    check("lat_ready_T", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("lat_no_early_rsp", 64'(rsp_valid), 64'd0);
    check("single_en_off", 64'(bram_en), 64'd0);
    @(posedge clk); #1;
    check("lat_rsp_T2", 64'(rsp_valid), 64'd1);
    wait_idle(50, 1'b0);
    check("single_beats", 64'(beat_cnt), 64'd1);
    check("single_data", last_data, 64'hDEADBEEFCAFEF00D);
    check("single_busy_done", 64'(busy), 64'd0);

    // Burst with a ready host: beats on consecutive cycles.
    clear_stats();
    do_req(16'h0004, 8'd3);
    wait_idle(50, 1'b0);
    check("burst_beats", 64'(beat_cnt), 64'(BURST ? 4 : 1));
    check("burst_last_data", last_data, BURST ? 64'd7 : 64'd4);
    check("burst_b2b", 64'(last_cyc - first_cyc), 64'(BURST ? 3 : 0));

    // Backpressure: issue stops once the buffer is committed.
    clear_stats();
    rsp_ready = 1'b0;
    do_req(16'h0100, 8'd7);
    repeat (10) begin
      @(posedge clk); #1;
    end
    check("bp_issue_count", 64'(iss_q.size()), 64'(BURST ? 4 : 1));
    check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
    rsp_ready = 1'b1;
    wait_idle(100, 1'b0);
    check("bp_beats", 64'(beat_cnt), 64'(BURST ? 8 : 1));
    check("bp_last_data", last_data, BURST ? 64'h0107 : 64'h0100);

    // Address wrap at the top of the BRAM.
    clear_stats();
    do_req(16'hFFFE, 8'd3);
    wait_idle(50, 1'b0);
    check("wrap_issue_count", 64'(iss_q.size()), 64'(BURST ? 4 : 1));
    for (int i = 0; i < iss_q.size() && i < 4; i++) begin
      check("wrap_addr", 64'(iss_q[i]), 64'(wrap_exp[i]));
    end

    // Reset during ISSUE after two reads were launched.
    clear_stats();
    rsp_ready = 1'b0;
    do_req(16'h0040, 8'd7);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    rsp_ready = 1'b1;
    clear_stats();
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("mid_rst_no_beats", 64'(beat_cnt), 64'd0);
    do_req(16'h0050, 8'd1);
    wait_idle(50, 1'b0);
    check("post_rst_beats", 64'(beat_cnt), 64'(BURST ? 2 : 1));

    // Vector table.
    for (int v = 0; v < 6; v++) begin
      clear_stats();
      rsp_ready = 1'b1;
      do_req(vecs[v].addr, vecs[v].len);
      wait_idle(300, vecs[v].rnd);
      rsp_ready = 1'b1;
      check("vec_beats", 64'(beat_cnt), 64'(vecs[v].exp_beats));
      check("vec_last_data", last_data, vecs[v].exp_last);
    end

    // Randomized requests against the beat-stream model.
    scramble = 1'b1;
    for (int n = 0; n < 20; n++) begin
      logic [15:0] a;
      logic [7:0]  l;
      bit          rnd;
      a   = 16'($urandom);
      l   = BURST ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      rnd = 1'($urandom_range(0, 1));
      clear_stats();
      rsp_ready = 1'b1;
      do_req(a, l);
      wait_idle(400, rnd);
      rsp_ready = 1'b1;
      check("rand_beats", 64'(beat_cnt), BURST ? 64'(int'(l) + 1) : 64'd1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/stats_readout_bridge.md
STATS_READOUT_BRIDGE -- requirements
Module: stats_readout_bridge

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Parameter ADDR_W SHALL default to 16 and set the BRAM word-address width.
REQ-003 Parameter DATA_W SHALL default to 64 and set the BRAM data width.
REQ-004 Parameter FIFO_DEPTH SHALL default to 4 and set the response buffer depth, which is a power of 2 and at least 2.
REQ-005 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock
- reset, in, 1, sync active-high reset
- req_valid, in, 1, host read request valid
- req_ready, out, 1, request accepted this cycle
- req_addr, in, ADDR_W, start word address
- req_len, in, 8, beat count minus 1
- rsp_valid, out, 1, response beat valid
- rsp_ready, in, 1, host accepts beat
- rsp_data, out, DATA_W, read data
- rsp_last, out, 1, final beat of request
- bram_addr, out, ADDR_W, stats BRAM port-B address
- bram_en, out, 1, stats BRAM port-B read enable
- bram_rdata, in, DATA_W, BRAM data, valid 1 cycle after bram_en
- busy, out, 1, request in progress

Function
REQ-006 The FSM SHALL have three states:
- IDLE: req_ready=1.
- ISSUE: entered on req_valid&&req_ready; latches addr and remaining=req_len.
- DRAIN: entered after the last BRAM read issues.
- DRAIN SHALL return to IDLE once no read is outstanding and the FIFO is empty.
REQ-007 req_ready SHALL be 1 only in IDLE, and busy SHALL be 1 in ISSUE and DRAIN.
REQ-008 In ISSUE, bram_en and bram_addr SHALL be registered outputs, with one read issued per cycle only while (FIFO occupancy + in-flight reads) < FIFO_DEPTH.
REQ-009 bram_rdata SHALL be written into the FIFO exactly one cycle after each bram_en, tagged last if it is the final beat.
REQ-010 The address SHALL increment by 1 per issued read and wrap from 2^ADDR_W-1 to 0.
REQ-011 Latency: with acceptance at edge T, bram_en SHALL be high during cycle T..T+1, data SHALL be captured at T+2, and rsp_valid SHALL be high from T+2 onward.
REQ-012 rsp_valid SHALL equal FIFO not-empty, and rsp_data/rsp_last SHALL hold stable while rsp_valid && !rsp_ready.
REQ-013 When the FIFO pops and pushes in the same cycle, occupancy SHALL stay unchanged with no data loss or duplication.
REQ-014 The block SHALL deliver exactly req_len+1 beats in address order, with rsp_last high only on the final one.
REQ-015 bram_en SHALL be 0 in IDLE and DRAIN, and bram_addr SHALL hold its last value when bram_en is 0.

Reset
REQ-016 Reset SHALL drive:
- state to IDLE and req_ready to 1;
- rsp_valid, rsp_last, bram_en and busy to 0;
- bram_addr and rsp_data to 0;
- FIFO pointers and in-flight count to 0.
REQ-017 Reset mid-request SHALL abort it and discard buffered and in-flight data, so no beat appears afterwards.

Configuration
REQ-018 With STATS_READ_BURST_EN defined, req_len SHALL be honoured as specified above.
REQ-019 Without STATS_READ_BURST_EN, req_len SHALL be ignored and treated as 0, so every request yields one beat with rsp_last=1 and the burst counter is not synthesized.

Verification
REQ-020 Single read: req addr 0x0010, len 0, BRAM returns 0xDEADBEEFCAFEF00D -> exactly one beat with that data, rsp_last=1, and busy back to 0.
REQ-021 Burst (macro on): addr 0x0004, len 3, BRAM data=addr -> beats 4,5,6,7 on back-to-back cycles with rsp_ready=1, and rsp_last only on 7.
REQ-022 Backpressure: len 7 with rsp_ready low for 10 cycles -> bram_en stops after 4 issues, and all 8 beats arrive in order once ready rises.
REQ-023 Wrap: addr 0xFFFE, len 3 -> bram_addr sequence FFFE, FFFF, 0000, 0001.
REQ-024 Reset in ISSUE after 2 beats are issued -> no further rsp_valid, req_ready=1 the next cycle, and a new request succeeds.
REQ-025 Macro off: addr 0x0020, len 5 -> one beat (0x20), rsp_last=1, and return to IDLE.
